fabric_loader: RTL and testbench

- Synthesizable host-side driver for the fabric's per-row instruction-load port and call/ret handshake.
- Reads a packed program image from a program memory and streams instructions into fabric rows. It then pulses call on all rows, waits for all rows to return, and reports the execution cycle count.
- Sits between the host/program SRAM and the fabric's instr_*_in, call and ret ports.

---
 rtl/fabric_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fabric_loader.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_loader.sv
// fabric_loader
// Host-side driver that walks a packed program image in program memory,
// streams each cell's instructions into the addressed fabric row, then
// pulses call on every row, waits for all rows to return and reports how
// many cycles the run took.
//
// Image layout (sequential from prog_base):
//   header word : [31:24] row, [23:16] col, [15:0] count
//   count instruction words follow each header; count==0 ends the image.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            begin load+run (only looked at while idle)
//   prog_base        address of the first header, captured on start
//   busy/done/error  status; done is a one-cycle pulse, error marks a bad header
//   cycles           measured run length, held until the next start
//   mem_re/mem_addr  program memory read port, mem_rdata returns one cycle later
//   instr_*_out      per-row instruction load bus to the fabric
//   call/ret         per-row call pulse out, return level in

module fabric_loader #(
  parameter int ROWS             = 2,
  parameter int COLS             = 2,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int INSTR_ADDR_WIDTH = 6,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int PROG_ADDR_WIDTH  = 10,
  parameter int CYCLE_CNT_WIDTH  = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [PROG_ADDR_WIDTH-1:0]               prog_base,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  output logic [CYCLE_CNT_WIDTH-1:0]               cycles,
  output logic                                     mem_re,
  output logic [PROG_ADDR_WIDTH-1:0]               mem_addr,
  input  logic [INSTR_DATA_WIDTH-1:0]              mem_rdata,
  output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]    instr_data_out,
  output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]    instr_addr_out,
  output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]    instr_hops_out,
  output logic [ROWS-1:0]                          instr_en_out,
  output logic [ROWS-1:0]                          call,
  input  logic [ROWS-1:0]                          ret
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [16:0] MAX_COUNT = 17'(1) << INSTR_ADDR_WIDTH;
  localparam logic [CYCLE_CNT_WIDTH-1:0] SETTLE_LAST = CYCLE_CNT_WIDTH'(2 * COLS);

  typedef enum logic [2:0] {
    IDLE, HDR, STREAM, CALL, SETTLE, WAIT_RET, DONE
  } state_t;

  state_t                                  state_q, state_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;
  logic                                    error_q, error_d;
  logic [CYCLE_CNT_WIDTH-1:0]              cycles_q, cycles_d;
  logic [CYCLE_CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic                                    mem_re_q, mem_re_d;
  logic [PROG_ADDR_WIDTH-1:0]              mem_addr_q, mem_addr_d;
  logic [PROG_ADDR_WIDTH-1:0]              ptr_q, ptr_d;
  logic                                    rvalid_q, rvalid_d;
  logic [ROW_W-1:0]                        row_q, row_d;
  logic [INSTR_HOPS_WIDTH-1:0]             col_q, col_d;
  logic [INSTR_ADDR_WIDTH-1:0]             idx_q, idx_d;
  logic [15:0]                             issue_left_q, issue_left_d;
  logic [15:0]                             recv_left_q, recv_left_d;
  logic [ROWS-1:0]                         call_q, call_d;
  logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]   instr_data_q, instr_data_d;
  logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]   instr_addr_q, instr_addr_d;
  logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]   instr_hops_q, instr_hops_d;
  logic [ROWS-1:0]                         instr_en_q, instr_en_d;

  logic [7:0]                              hdr_row;
  logic [7:0]                              hdr_col;
  logic [15:0]                             hdr_count;
  logic                                    hdr_bad;
  logic [CYCLE_CNT_WIDTH-1:0]              cnt_inc;

  assign hdr_row   = mem_rdata[31:24];
  assign hdr_col   = mem_rdata[23:16];
  assign hdr_count = mem_rdata[15:0];
  assign hdr_bad   = (int'(hdr_row) >= ROWS) || (int'(hdr_col) >= COLS) ||
                     ({1'b0, hdr_count} > MAX_COUNT);

  // Run-length counter saturates instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYCLE_CNT_WIDTH'(1);

  // Next-state and registered-output logic. Every output is a flop so the
  // fabric and the memory see clean, glitch-free signals. Reads are issued
  // back-to-back during a cell; rvalid_q marks the cycle mem_rdata is good.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    cycles_d     = cycles_q;
    cnt_d        = cnt_q;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    ptr_d        = ptr_q;
    rvalid_d     = mem_re_q;
    row_d        = row_q;
    col_d        = col_q;
    idx_d        = idx_q;
    issue_left_d = issue_left_q;
    recv_left_d  = recv_left_q;
    call_d       = '0;
    instr_data_d = '0;
    instr_addr_d = '0;
    instr_hops_d = '0;
    instr_en_d   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          error_d    = 1'b0;
          cycles_d   = '0;
          mem_re_d   = 1'b1;
          mem_addr_d = prog_base;
          ptr_d      = prog_base + PROG_ADDR_WIDTH'(1);
          state_d    = HDR;
        end
      end
      HDR: begin
        if (rvalid_q) begin
          if (hdr_bad) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else if (hdr_count == 16'd0) begin
            call_d  = '1;
            cnt_d   = '0;
            state_d = CALL;
          end else begin
            // First instruction read goes out together with the decode.
            row_d        = ROW_W'(hdr_row);
            col_d        = INSTR_HOPS_WIDTH'(hdr_col);
            idx_d        = '0;
            issue_left_d = hdr_count - 16'd1;
            recv_left_d  = hdr_count;
            mem_re_d     = 1'b1;
            mem_addr_d   = ptr_q;
            ptr_d        = ptr_q + PROG_ADDR_WIDTH'(1);
            state_d      = STREAM;
          end
        end
      end
      STREAM: begin
        if (issue_left_q != 16'd0) begin
          mem_re_d     = 1'b1;
          mem_addr_d   = ptr_q;
          ptr_d        = ptr_q + PROG_ADDR_WIDTH'(1);
          issue_left_d = issue_left_q - 16'd1;
        end
        if (rvalid_q) begin
          instr_en_d[row_q]   = 1'b1;
          instr_data_d[row_q] = mem_rdata;
          instr_addr_d[row_q] = idx_q;
          instr_hops_d[row_q] = col_q;
          idx_d               = idx_q + INSTR_ADDR_WIDTH'(1);
          recv_left_d         = recv_left_q - 16'd1;
          // Last word of the cell: the next header sits right after it.
          if (recv_left_q == 16'd1) begin
            mem_re_d   = 1'b1;
            mem_addr_d = ptr_q;
            ptr_d      = ptr_q + PROG_ADDR_WIDTH'(1);
            state_d    = HDR;
          end
        end
      end
      CALL: begin
        cnt_d   = cnt_inc;
        state_d = SETTLE;
      end
      SETTLE: begin
        // ret from the previous program may still be high; ignore it here.
        cnt_d = cnt_inc;
        if (cnt_q >= SETTLE_LAST) begin
          state_d = WAIT_RET;
        end
      end
      WAIT_RET: begin
        cnt_d = cnt_inc;
        if (&ret) begin
          cycles_d = cnt_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cycles_q     <= '0;
      cnt_q        <= '0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      ptr_q        <= '0;
      rvalid_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      issue_left_q <= '0;
      recv_left_q  <= '0;
      call_q       <= '0;
      instr_data_q <= '0;
      instr_addr_q <= '0;
      instr_hops_q <= '0;
      instr_en_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cycles_q     <= cycles_d;
      cnt_q        <= cnt_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      ptr_q        <= ptr_d;
      rvalid_q     <= rvalid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      issue_left_q <= issue_left_d;
      recv_left_q  <= recv_left_d;
      call_q       <= call_d;
      instr_data_q <= instr_data_d;
      instr_addr_q <= instr_addr_d;
      instr_hops_q <= instr_hops_d;
      instr_en_q   <= instr_en_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign cycles         = cycles_q;
  assign mem_re         = mem_re_q;
  assign mem_addr       = mem_addr_q;
  assign call           = call_q;
  assign instr_data_out = instr_data_q;
  assign instr_addr_out = instr_addr_q;
  assign instr_hops_out = instr_hops_q;
  assign instr_en_out   = instr_en_q;

endmodule

// File: tb/tb_fabric_loader.sv
// tb_fabric_loader
// Drives program images into a behavioural program memory, plays the fabric's
// ret response, and compares every instruction load, the call pulse, the
// done pulse and the reported cycle count against a model that interprets
// the image directly.

module tb_fabric_loader;

  localparam int ROWS    = 2;
  localparam int COLS    = 2;
  localparam int DW      = 32;
  localparam int AW      = 6;
  localparam int HW      = 4;
  localparam int PW      = 10;
  localparam int CW      = 32;
  localparam int MIN_CYC = 2 * COLS + 1;

  typedef struct {
    int            row;
    int            addr;
    int            hops;
    logic [DW-1:0] data;
    int            cyc;
  } load_t;

  typedef struct {
    int            cyc;
    logic          busy;
    logic          err;
    logic [CW-1:0] cycles;
  } done_t;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
  logic [PW-1:0]              prog_base;
  logic                       busy;
  logic                       done;
  logic                       error;
  logic [CW-1:0]              cycles;
  logic                       mem_re;
  logic [PW-1:0]              mem_addr;
  logic [DW-1:0]              mem_rdata;
  logic [ROWS-1:0][DW-1:0]    instr_data_out;
  logic [ROWS-1:0][AW-1:0]    instr_addr_out;
  logic [ROWS-1:0][HW-1:0]    instr_hops_out;
  logic [ROWS-1:0]            instr_en_out;
  logic [ROWS-1:0]            call;
  logic [ROWS-1:0]            ret;

  logic [DW-1:0] mem [0:1023];
  int            cyc = 0;

  load_t  obs_q[$];
  int     call_q[$];
  done_t  done_q[$];
  int     viol = 0;
  int     last_call_cyc = 0;
  int     last_call_run = -1;
  int     run_id = 0;
  int     ret_at = 0;

  logic [31:0] img_q[$];
  load_t       exp_q[$];
  bit          exp_err;
  int          n_checks = 0;
  int          n_fail = 0;

  fabric_loader #(
    .ROWS(ROWS), .COLS(COLS), .INSTR_DATA_WIDTH(DW), .INSTR_ADDR_WIDTH(AW),
    .INSTR_HOPS_WIDTH(HW), .PROG_ADDR_WIDTH(PW), .CYCLE_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_base(prog_base),
    .busy(busy), .done(done), .error(error), .cycles(cycles),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_data_out(instr_data_out), .instr_addr_out(instr_addr_out),
    .instr_hops_out(instr_hops_out), .instr_en_out(instr_en_out),
    .call(call), .ret(ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory with one-cycle read latency, plus a free-running cycle index.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re === 1'b1) mem_rdata <= mem[mem_addr];
  end

  // Monitor sampled mid-cycle: records loads, call and done events, counts
  // bus-hygiene violations, and plays the fabric's ret level.
  always @(negedge clk) begin
    int    n_en;
    load_t l;
    done_t d;
    n_en = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (instr_en_out[r] === 1'b1) begin
        n_en++;
        l.row  = r;
        l.addr = int'(instr_addr_out[r]);
        l.hops = int'(instr_hops_out[r]);
        l.data = instr_data_out[r];
        l.cyc  = cyc;
        obs_q.push_back(l);
      end else if (instr_data_out[r] !== '0 || instr_addr_out[r] !== '0 ||
                   instr_hops_out[r] !== '0) begin
        viol++;
      end
    end
    if (n_en > 1) viol++;
    if (call !== '0) begin
      if (call !== '1) viol++;
      call_q.push_back(cyc);
      last_call_cyc = cyc;
      last_call_run = run_id;
    end
    if (done === 1'b1) begin
      d.cyc    = cyc;
      d.busy   = busy;
      d.err    = error;
      d.cycles = cycles;
      done_q.push_back(d);
    end
    ret = (ret_at == 0 || (last_call_run == run_id && (cyc - last_call_cyc) >= ret_at)) ? '1 : '0;
  end

  // Interpret img_q as the loader should: list of expected loads and error flag.
  task automatic model_image();
    int i;
    int row, col, cnt;
    load_t l;
    exp_q.delete();
    exp_err = 1'b0;
    i = 0;
    while (i < img_q.size()) begin
      row = int'(img_q[i][31:24]);
      col = int'(img_q[i][23:16]);
      cnt = int'(img_q[i][15:0]);
      if (cnt == 0) break;
      if (row >= ROWS || col >= COLS || cnt > (1 << AW)) begin
        exp_err = 1'b1;
        break;
      end
      for (int k = 0; k < cnt; k++) begin
        l.row = row; l.addr = k; l.hops = col; l.data = img_q[i + 1 + k]; l.cyc = 0;
        exp_q.push_back(l);
      end
      i += 1 + cnt;
    end
  endtask

  task automatic load_image(input int base);
    for (int i = 0; i < img_q.size(); i++) mem[(base + i) % 1024] = img_q[i];
  endtask

  task automatic add_cell(input int row, input int col, input int cnt);
    img_q.push_back({8'(row), 8'(col), 16'(cnt)});
    for (int k = 0; k < cnt; k++) img_q.push_back($urandom);
  endtask

  // Pulse start, then wait (bounded) for the done pulse.
  task automatic run_image(input int base, input int ret_at_i, output bit timed_out,
                           output logic busy_after, output logic err_after);
    int d0;
    run_id++;
    ret_at = ret_at_i;
    d0 = done_q.size();
    @(negedge clk); #1;
    prog_base = PW'(base);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    busy_after = busy;
    err_after = error;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done_q.size() > d0) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    prog_base = '0;
    ret_at = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_error: got %b want 0", error); end
    n_checks++; if (cycles !== '0) begin n_fail++; $display("[TB] FAIL reset_cycles: got %0d want 0", cycles); end
    n_checks++; if (mem_re !== 1'b0 || mem_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_mem: got re=%b addr=%0h want 0", mem_re, mem_addr); end
    n_checks++; if (call !== '0) begin n_fail++; $display("[TB] FAIL reset_call: got %b want 00", call); end
    n_checks++;
    if (instr_en_out !== '0 || instr_data_out !== '0 || instr_addr_out !== '0 || instr_hops_out !== '0) begin
      n_fail++; $display("[TB] FAIL reset_instr: got en=%b data=%0h want all 0", instr_en_out, instr_data_out);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One cell of three words on row 0, ret rising at T8.
  task automatic test_single_cell();
    bit to; logic ba, ea;
    int s0, c0, d0, v0;
    img_q.delete();
    img_q.push_back(32'h0001_0003);
    img_q.push_back(32'hA0A0_0001);
    img_q.push_back(32'hB0B0_0002);
    img_q.push_back(32'hC0C0_0003);
    img_q.push_back(32'h0000_0000);
    load_image(0);
    model_image();
    s0 = obs_q.size(); c0 = call_q.size(); d0 = done_q.size(); v0 = viol;
    run_image(0, 8, to, ba, ea);
    n_checks++; if (to) begin n_fail++; $display("[TB] FAIL single_timeout: no done within bound"); end
    n_checks++; if (ba !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy: got %b want 1", ba); end
    n_checks++;
    if (obs_q.size() - s0 != 3) begin
      n_fail++; $display("[TB] FAIL single_nloads: got %0d want 3", obs_q.size() - s0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_q[s0+i].row !== exp_q[i].row || obs_q[s0+i].addr !== exp_q[i].addr ||
            obs_q[s0+i].hops !== exp_q[i].hops || obs_q[s0+i].data !== exp_q[i].data) begin
          n_fail++; $display("[TB] FAIL single_load%0d: got r%0d a%0d h%0d d%0h want r%0d a%0d h%0d d%0h", i,
            obs_q[s0+i].row, obs_q[s0+i].addr, obs_q[s0+i].hops, obs_q[s0+i].data,
            exp_q[i].row, exp_q[i].addr, exp_q[i].hops, exp_q[i].data);
        end
      end
      n_checks++;
      if (obs_q[s0+2].cyc - obs_q[s0].cyc != 2) begin
        n_fail++; $display("[TB] FAIL single_consecutive: span %0d want 2", obs_q[s0+2].cyc - obs_q[s0].cyc);
      end
      n_checks++;
      if (call_q.size() - c0 != 1) begin
        n_fail++; $display("[TB] FAIL single_ncall: got %0d want 1", call_q.size() - c0);
      end else if (call_q[c0] - obs_q[s0+2].cyc != 2) begin
        n_fail++; $display("[TB] FAIL single_call_gap: got %0d want 2", call_q[c0] - obs_q[s0+2].cyc);
      end
    end
    n_checks++;
    if (done_q.size() - d0 != 1) begin
      n_fail++; $display("[TB] FAIL single_ndone: got %0d want 1", done_q.size() - d0);
    end else begin
      n_checks++; if (done_q[d0].cycles !== 32'd8) begin n_fail++; $display("[TB] FAIL single_cycles: got %0d want 8", done_q[d0].cycles); end
      n_checks++; if (done_q[d0].busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_done_busy: got %b want 0", done_q[d0].busy); end
      n_checks++;
      if (call_q.size() > c0 && done_q[d0].cyc - call_q[c0] != 9) begin
        n_fail++; $display("[TB] FAIL single_done_time: got T%0d want T9", done_q[d0].cyc - call_q[c0]);
      end
    end
    n_checks++; if (viol != v0) begin n_fail++; $display("[TB] FAIL single_bus_hygiene: got %0d violations want 0", viol - v0); end
  endtask

  // Two cells on different rows, ret held high throughout.
  task automatic test_multi_cell();
    bit to; logic ba, ea;
    int s0, c0, d0, v0;
    img_q.delete();
    img_q.push_back(32'h0100_0002);
    img_q.push_back(32'hD0D0_0004);
    img_q.push_back(32'hE0E0_0005);
    img_q.push_back(32'h0001_0001);
    img_q.push_back(32'hF0F0_0006);
    img_q.push_back(32'h0000_0000);
    load_image(40);
    model_image();
    s0 = obs_q.size(); c0 = call_q.size(); d0 = done_q.size(); v0 = viol;
    run_image(40, 0, to, ba, ea);
    n_checks++; if (to) begin n_fail++; $display("[TB] FAIL multi_timeout: no done within bound"); end
    n_checks++;
    if (obs_q.size() - s0 != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL multi_nloads: got %0d want %0d", obs_q.size() - s0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[s0+i].row !== exp_q[i].row || obs_q[s0+i].addr !== exp_q[i].addr ||
            obs_q[s0+i].hops !== exp_q[i].hops || obs_q[s0+i].data !== exp_q[i].data) begin
          n_fail++; $display("[TB] FAIL multi_load%0d: got r%0d a%0d h%0d d%0h want r%0d a%0d h%0d d%0h", i,
            obs_q[s0+i].row, obs_q[s0+i].addr, obs_q[s0+i].hops, obs_q[s0+i].data,
            exp_q[i].row, exp_q[i].addr, exp_q[i].hops, exp_q[i].data);
        end
      end
    end
    n_checks++; if (call_q.size() - c0 != 1) begin n_fail++; $display("[TB] FAIL multi_ncall: got %0d want 1", call_q.size() - c0); end
    n_checks++;
    if (done_q.size() - d0 != 1) begin
      n_fail++; $display("[TB] FAIL multi_ndone: got %0d want 1", done_q.size() - d0);
    end else if (done_q[d0].cycles !== CW'(MIN_CYC)) begin
      n_fail++; $display("[TB] FAIL multi_cycles: got %0d want %0d", done_q[d0].cycles, MIN_CYC);
    end
    n_checks++; if (viol != v0) begin n_fail++; $display("[TB] FAIL multi_bus_hygiene: got %0d violations want 0", viol - v0); end
  endtask

  // Bad headers abort with error; a good run afterwards clears it.
  task automatic test_error();
    bit to; logic ba, ea;
    int s0, c0, d0;
    logic [31:0] bad_hdr [3];
    bad_hdr[0] = 32'h0200_0001;
    bad_hdr[1] = 32'h0002_0001;
    bad_hdr[2] = 32'h0100_0041;
    for (int b = 0; b < 3; b++) begin
      img_q.delete();
      img_q.push_back(bad_hdr[b]);
      img_q.push_back(32'h1234_5678);
      img_q.push_back(32'h0000_0000);
      load_image(300);
      model_image();
      s0 = obs_q.size(); c0 = call_q.size(); d0 = done_q.size();
      run_image(300, 0, to, ba, ea);
      n_checks++; if (to) begin n_fail++; $display("[TB] FAIL error%0d_timeout: no done within bound", b); end
      n_checks++;
      if (done_q.size() - d0 != 1) begin
        n_fail++; $display("[TB] FAIL error%0d_ndone: got %0d want 1", b, done_q.size() - d0);
      end else if (done_q[d0].err !== exp_err || done_q[d0].busy !== 1'b0) begin
        n_fail++; $display("[TB] FAIL error%0d_flag: got err=%b busy=%b want err=%b busy=0", b, done_q[d0].err, done_q[d0].busy, exp_err);
      end
      n_checks++;
      if (call_q.size() != c0 || obs_q.size() != s0) begin
        n_fail++; $display("[TB] FAIL error%0d_quiet: got %0d calls %0d loads want 0 0", b, call_q.size() - c0, obs_q.size() - s0);
      end
    end
    // Largest legal cell: 2^AW instructions, index runs to the top.
    img_q.delete();
    add_cell(1, 1, 1 << AW);
    img_q.push_back(32'h0000_0000);
    load_image(400);
    model_image();
    s0 = obs_q.size(); d0 = done_q.size();
    run_image(400, 0, to, ba, ea);
    n_checks++; if (ea !== 1'b0) begin n_fail++; $display("[TB] FAIL error_clear_on_start: got %b want 0", ea); end
    n_checks++; if (to) begin n_fail++; $display("[TB] FAIL maxcnt_timeout: no done within bound"); end
    n_checks++;
    if (obs_q.size() - s0 != (1 << AW)) begin
      n_fail++; $display("[TB] FAIL maxcnt_nloads: got %0d want %0d", obs_q.size() - s0, 1 << AW);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[s0+i].row !== exp_q[i].row || obs_q[s0+i].addr !== exp_q[i].addr ||
            obs_q[s0+i].hops !== exp_q[i].hops || obs_q[s0+i].data !== exp_q[i].data) begin
          n_fail++; $display("[TB] FAIL maxcnt_load%0d: got a%0d d%0h want a%0d d%0h", i,
            obs_q[s0+i].addr, obs_q[s0+i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
    n_checks++;
    if (done_q.size() - d0 != 1 || done_q[d0].err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL maxcnt_done: got %0d pulses want 1 with err 0", done_q.size() - d0);
    end
  endtask

  // Reset while the second of three words is on the bus, then rerun.
  task automatic test_reset_midstream();
    bit to; logic ba, ea;
    int s0, c0, d0;
    bit seen;
    img_q.delete();
    add_cell(0, 1, 3);
    img_q.push_back(32'h0000_0000);
    load_image(200);
    model_image();
    s0 = obs_q.size(); c0 = call_q.size(); d0 = done_q.size();
    run_id++;
    ret_at = 0;
    @(negedge clk); #1;
    prog_base = PW'(200);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (obs_q.size() >= s0 + 2) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL midrst_second_word: not seen within bound"); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || instr_en_out !== '0 || instr_data_out !== '0 ||
        call !== '0 || mem_re !== 1'b0 || cycles !== '0) begin
      n_fail++; $display("[TB] FAIL midrst_outputs: got busy=%b done=%b en=%b call=%b re=%b want all 0", busy, done, instr_en_out, call, mem_re);
    end
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (done_q.size() != d0 || call_q.size() != c0 || obs_q.size() - s0 != 2) begin
      n_fail++; $display("[TB] FAIL midrst_abort: got %0d done %0d call %0d loads want 0 0 2", done_q.size() - d0, call_q.size() - c0, obs_q.size() - s0);
    end
    s0 = obs_q.size(); d0 = done_q.size();
    run_image(200, 0, to, ba, ea);
    n_checks++; if (to) begin n_fail++; $display("[TB] FAIL midrst_rerun_timeout: no done within bound"); end
    n_checks++;
    if (obs_q.size() - s0 != 3) begin
      n_fail++; $display("[TB] FAIL midrst_rerun_nloads: got %0d want 3", obs_q.size() - s0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_q[s0+i].addr !== exp_q[i].addr || obs_q[s0+i].data !== exp_q[i].data || obs_q[s0+i].row !== exp_q[i].row) begin
          n_fail++; $display("[TB] FAIL midrst_rerun_load%0d: got a%0d d%0h want a%0d d%0h", i, obs_q[s0+i].addr, obs_q[s0+i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
  endtask

  // Random images, bases and ret timing against the image interpreter.
  task automatic test_random();
    bit to; logic ba, ea;
    int s0, c0, d0, v0, base, rat, ncell, exp_cyc;
    for (int it = 0; it < 8; it++) begin
      img_q.delete();
      ncell = $urandom_range(1, 3);
      for (int c = 0; c < ncell; c++) add_cell($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1), $urandom_range(1, 6));
      img_q.push_back(32'h0000_0000);
      base = $urandom_range(0, 900);
      rat = $urandom_range(0, 12);
      exp_cyc = (rat > MIN_CYC) ? rat : MIN_CYC;
      load_image(base);
      model_image();
      s0 = obs_q.size(); c0 = call_q.size(); d0 = done_q.size(); v0 = viol;
      run_image(base, rat, to, ba, ea);
      n_checks++; if (to) begin n_fail++; $display("[TB] FAIL rand%0d_timeout: no done within bound", it); end
      n_checks++;
      if (obs_q.size() - s0 != exp_q.size()) begin
        n_fail++; $display("[TB] FAIL rand%0d_nloads: got %0d want %0d", it, obs_q.size() - s0, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (obs_q[s0+i].row !== exp_q[i].row || obs_q[s0+i].addr !== exp_q[i].addr ||
              obs_q[s0+i].hops !== exp_q[i].hops || obs_q[s0+i].data !== exp_q[i].data) begin
            n_fail++; $display("[TB] FAIL rand%0d_load%0d: got r%0d a%0d h%0d d%0h want r%0d a%0d h%0d d%0h", it, i,
              obs_q[s0+i].row, obs_q[s0+i].addr, obs_q[s0+i].hops, obs_q[s0+i].data,
              exp_q[i].row, exp_q[i].addr, exp_q[i].hops, exp_q[i].data);
          end
        end
      end
      n_checks++;
      if (call_q.size() - c0 != 1 || done_q.size() - d0 != 1) begin
        n_fail++; $display("[TB] FAIL rand%0d_pulses: got %0d call %0d done want 1 1", it, call_q.size() - c0, done_q.size() - d0);
      end else begin
        n_checks++;
        if (done_q[d0].cycles !== CW'(exp_cyc) || done_q[d0].cyc - call_q[c0] != exp_cyc + 1) begin
          n_fail++; $display("[TB] FAIL rand%0d_cycles: got %0d at T%0d want %0d at T%0d", it,
            done_q[d0].cycles, done_q[d0].cyc - call_q[c0], exp_cyc, exp_cyc + 1);
        end
        n_checks++;
        if (done_q[d0].busy !== 1'b0 || done_q[d0].err !== 1'b0) begin
          n_fail++; $display("[TB] FAIL rand%0d_done_flags: got busy=%b err=%b want 0 0", it, done_q[d0].busy, done_q[d0].err);
        end
      end
      n_checks++; if (viol != v0) begin n_fail++; $display("[TB] FAIL rand%0d_bus_hygiene: got %0d violations want 0", it, viol - v0); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    prog_base = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    $display("[TB] fabric_loader bench starting");
    test_reset();
    test_single_cell();
    test_multi_cell();
    test_error();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
